// File: rtl/pe_fetch_pkg.sv
// Shared types and width helpers for the PE instruction-fetch stage.
package pe_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    FETCH  = 2'd2,
    DRAIN  = 2'd3
  } fetch_state_t;

  function automatic int pc_w(input int inst_word);
    return (inst_word > 1) ? $clog2(inst_word) : 1;
  endfunction

  // One extra bit so a full bank (INST_WORD words) is representable.
  function automatic int len_w(input int inst_word);
    return pc_w(inst_word) + 1;
  endfunction

endpackage

// File: rtl/pe_fetch.sv
// Program counter / instruction fetch: walks prog_len words iter times over the
// banked instruction memory and hands each word to decode with a valid/stall handshake.
//
// state  | meaning
// IDLE   | waiting for start_i, memory idle
// LAUNCH | one cycle, pulses r_switch_o to advance the read bank
// FETCH  | issues one read per unstalled cycle, pc wraps per iteration
// DRAIN  | waits for the last read to be accepted, then pulses done_o
module pe_fetch
  import pe_fetch_pkg::*;
#(
  parameter int INST_WIDTH = 64,
  parameter int INST_WORD  = 32,
  parameter int ITER_W     = 8,
  localparam int PC_W      = pc_w(INST_WORD),
  localparam int LEN_W     = len_w(INST_WORD)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [LEN_W-1:0]      prog_len_i,
  input  logic [ITER_W-1:0]     iter_i,
  input  logic                  stall_i,
  output logic [PC_W-1:0]       addr_r,
  output logic                  cen_r,
  output logic                  gwen_r,
  output logic                  r_switch_o,
  input  logic [INST_WIDTH-1:0] inst_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic                  inst_valid_o,
  output logic                  busy_o,
  output logic                  done_o
);

  fetch_state_t      state;
  logic [PC_W-1:0]   pc;
  logic [LEN_W-1:0]  len;
  logic [ITER_W-1:0] iter;
  logic [ITER_W-1:0] iter_cnt;
  logic              rd_pend;
  logic              issue;
  logic              last_word;
  logic              last_iter;

  assign issue     = (state == FETCH) && !stall_i;
  assign last_word = ({1'b0, pc} == (len - LEN_W'(1)));
  assign last_iter = (iter_cnt == (iter - ITER_W'(1)));

  assign cen_r        = !issue;
  assign gwen_r       = 1'b1;
  assign addr_r       = pc;
  assign r_switch_o   = (state == LAUNCH);
  assign inst_o       = inst_i;
  assign inst_valid_o = rd_pend;
  assign busy_o       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= '0;
      len      <= '0;
      iter     <= '0;
      iter_cnt <= '0;
      rd_pend  <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      done_o  <= 1'b0;
      // A stalled word stays pending; the SRAM output holds because no read is issued.
      rd_pend <= issue | (rd_pend & stall_i);
      if (abort_i) begin
        state   <= IDLE;
        rd_pend <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              len      <= prog_len_i;
              iter     <= (iter_i == '0) ? ITER_W'(1) : iter_i;
              pc       <= '0;
              iter_cnt <= '0;
              state    <= LAUNCH;
            end
          end
          LAUNCH: state <= (len == '0) ? DRAIN : FETCH;
          FETCH: begin
            if (issue) begin
              if (last_word) begin
                if (last_iter) begin
                  state <= DRAIN;
                end else begin
                  pc       <= '0;
                  iter_cnt <= iter_cnt + ITER_W'(1);
                end
              end else begin
                pc <= pc + PC_W'(1);
              end
            end
          end
          DRAIN: begin
            if (!(rd_pend && stall_i)) begin
              state  <= IDLE;
              done_o <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pe_fetch.sv
// Scoreboard bench for pe_fetch: a banked SRAM model feeds the DUT, expected words are queued per run.
module tb_pe_fetch;

  localparam int INST_WIDTH = 64;
  localparam int INST_WORD  = 32;
  localparam int ITER_W     = 8;
  localparam int PC_W       = 5;
  localparam int LEN_W      = 6;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start_i = 1'b0;
  logic                  abort_i = 1'b0;
  logic                  stall_i = 1'b0;
  logic [LEN_W-1:0]      prog_len_i = '0;
  logic [ITER_W-1:0]     iter_i = '0;
  logic [PC_W-1:0]       addr_r;
  logic                  cen_r, gwen_r, r_switch_o;
  logic [INST_WIDTH-1:0] inst_i, inst_o;
  logic                  inst_valid_o, busy_o, done_o;

  int n_chk = 0;
  int n_fail = 0;
  int exp_bank = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_w;

  int          sram_bank;
  logic [63:0] sram_q;

  pe_fetch #(.INST_WIDTH(INST_WIDTH), .INST_WORD(INST_WORD), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .prog_len_i(prog_len_i), .iter_i(iter_i), .stall_i(stall_i),
    .addr_r(addr_r), .cen_r(cen_r), .gwen_r(gwen_r), .r_switch_o(r_switch_o),
    .inst_i(inst_i), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word_of(input int b, input int a);
    return {8'(160 + b), 24'(a), 32'(a * 7919 + b * 104729) ^ 32'h5A5A_0000};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Triple-banked instruction memory: read data appears one cycle after a cen_r=0 cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_bank <= 0;
      sram_q    <= '0;
    end else begin
      if (r_switch_o) sram_bank <= (sram_bank + 1) % 3;
      if (!cen_r) sram_q <= word_of(sram_bank, int'(addr_r));
    end
  end
  assign inst_i = sram_q;

  // Monitor: every word decode accepts must be the next expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_i) check("no_read_while_stalled", 64'(cen_r), 64'(1));
      if (!cen_r) check("gwen_read_only", 64'(gwen_r), 64'(1));
      if (inst_valid_o && !stall_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(inst_valid_o), 64'(0));
        end else begin
          mon_w = exp_q.pop_front();
          check("inst_word", inst_o, mon_w);
        end
      end
    end
  end

  task automatic run(input int len, input int iter, input int stall_pct, input int st_lo,
                     input int st_hi, input int abort_k, input int busy_start_k,
                     input int exp_done);
    int eff, nwords, sw, done_k, limit;
    bit det;
    eff    = (iter == 0) ? 1 : iter;
    nwords = len * eff;
    if (abort_k >= 0 && abort_k - 2 < nwords) nwords = abort_k - 2;
    det    = (stall_pct == 0) && (st_lo < 0) && (abort_k < 0);
    @(posedge clk); #1;
    prog_len_i = LEN_W'(len);
    iter_i     = ITER_W'(iter);
    start_i    = 1'b1;
    abort_i    = 1'b0;
    stall_i    = 1'b0;
    exp_bank   = (exp_bank + 1) % 3;
    for (int w = 0; w < nwords; w++) exp_q.push_back(word_of(exp_bank, w % len));
    sw     = 0;
    done_k = -1;
    limit  = (abort_k >= 0) ? abort_k + 6 : 3000;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      start_i = (k == busy_start_k);
      abort_i = (k == abort_k);
      stall_i = (k >= st_lo && k <= st_hi) || (int'($urandom_range(0, 99)) < stall_pct);
      @(negedge clk);
      if (r_switch_o) sw++;
      if (k == 1) check("r_switch_at_1", 64'(r_switch_o), 64'(1));
      if (det && k >= 2 && k <= 1 + len * eff) begin
        check("cen_issue", 64'(cen_r), 64'(0));
        check("addr_seq", 64'(addr_r), 64'((k - 2) % len));
      end
      if (det) check("valid_window", 64'(inst_valid_o), 64'(k >= 3 && k <= 2 + len * eff));
      if (exp_done > 0 && (k == 1 || k == exp_done - 1 || k == exp_done))
        check("busy", 64'(busy_o), 64'(k < exp_done));
      if (k == abort_k + 1) begin
        check("abort_idle", 64'(busy_o), 64'(0));
        check("abort_valid", 64'(inst_valid_o), 64'(0));
      end
      if (done_o && done_k < 0) done_k = k;
      if (abort_k < 0 && done_k >= 0) break;
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    stall_i = 1'b0;
    check("switch_count", 64'(sw), 64'(1));
    if (abort_k < 0) begin
      check("done_seen", 64'(done_k >= 0), 64'(1));
      if (exp_done > 0) check("done_cycle", 64'(done_k), 64'(exp_done));
    end else begin
      check("no_done_after_abort", 64'(done_k), 64'(-1));
    end
    check("words_left", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cen", 64'(cen_r), 64'(1));
    check("rst_gwen", 64'(gwen_r), 64'(1));
    check("rst_addr", 64'(addr_r), 64'(0));
    check("rst_switch", 64'(r_switch_o), 64'(0));
    check("rst_valid", 64'(inst_valid_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    rst_n = 1'b1;

    run(4, 1, 0, -1, -1, -1, -1, 7);
    run(3, 2, 0, -1, -1, -1, -1, 9);
    run(4, 1, 0, 4, 5, -1, -1, 9);
    run(0, 1, 0, -1, -1, -1, -1, 3);
    run(32, 1, 0, -1, -1, -1, -1, 35);
    run(4, 0, 0, -1, -1, -1, -1, 7);
    run(8, 1, 0, -1, -1, 4, -1, -1);
    run(5, 2, 0, -1, -1, -1, 3, 13);

    // start and abort together in IDLE: abort wins
    @(posedge clk); #1;
    start_i = 1'b1;
    abort_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    @(negedge clk);
    check("start_abort_idle", 64'(busy_o), 64'(0));
    check("start_abort_switch", 64'(r_switch_o), 64'(0));

    for (int r = 0; r < 8; r++)
      run(int'($urandom_range(1, 32)), int'($urandom_range(0, 3)), 30, -1, -1, -1, -1, -1);

    // asynchronous reset in the middle of FETCH
    @(posedge clk); #1;
    prog_len_i = LEN_W'(8);
    iter_i     = ITER_W'(1);
    start_i    = 1'b1;
    exp_bank   = (exp_bank + 1) % 3;
    for (int w = 0; w < 8; w++) exp_q.push_back(word_of(exp_bank, w));
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_cen", 64'(cen_r), 64'(1));
    check("midrst_addr", 64'(addr_r), 64'(0));
    check("midrst_valid", 64'(inst_valid_o), 64'(0));
    check("midrst_busy", 64'(busy_o), 64'(0));
    check("midrst_done", 64'(done_o), 64'(0));
    exp_q.delete();
    exp_bank = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(2, 1, 0, -1, -1, -1, -1, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
